// File: rtl/seq_code_lock_pkg.sv
// Shared definitions for the sequential code lock.
//   lock_state_e : FSM state encoding (2'd3 is illegal and recovers to ENTRY)
//   clog2_safe   : $clog2 clamped to a minimum width of 1
//   max_int      : larger of two integers, for width calculations
package seq_code_lock_pkg;

   typedef enum logic [1:0] {
      ENTRY   = 2'd0,
      OPEN    = 2'd1,
      LOCKOUT = 2'd2
   } lock_state_e;

   function automatic int clog2_safe(input int v);
      int w;
      w = $clog2(v);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/seq_code_lock_timer.sv
// Loadable down-counter used for both the unlock hold and the lockout period.
//   clk      : clock, rising edge
//   reset    : synchronous, active-high
//   load     : load load_val and start counting
//   load_val : initial count (period - 1)
//   expired  : high on the last cycle of the period (count==0 while active)
module lock_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] count;
   logic         active;

   always_ff @(posedge clk) begin
      if (reset) begin
         count  <= '0;
         active <= 1'b0;
      end else if (load) begin
         count  <= load_val;
         active <= 1'b1;
      end else if (active) begin
         // Stop at zero so expired lasts exactly one cycle.
         if (count == '0) active <= 1'b0;
         else             count  <= count - 1'b1;
      end
   end

   assign expired = active && (count == '0);

endmodule

// File: rtl/seq_code_lock.sv
// Parametrised sequential combination lock.
// Accepts N_STEPS codes of CODE_W bits, one per enter strobe. A complete
// correct sequence holds unlocked high for UNLOCK_CYCLES cycles; MAX_FAILS
// wrong entries in a row force a LOCKOUT_CYCLES lockout (MAX_FAILS=0
// disables lockout).
//   clk      : clock, rising edge
//   reset    : synchronous, active-high
//   code_in  : code word, sampled only when enter=1
//   enter    : entry strobe, every high cycle is one entry
//   unlocked : high while OPEN
//   lockout  : high while LOCKOUT
//   step     : index of the next expected code
//   fails    : wrong entries since last success or lockout
//   err      : one-cycle pulse after a wrong entry
module seq_code_lock
   import seq_code_lock_pkg::*;
#(
   parameter int                          CODE_W         = 5,
   parameter int                          N_STEPS        = 3,
   parameter logic [N_STEPS*CODE_W-1:0]   CODES          = 15'h7590,
   parameter int                          UNLOCK_CYCLES  = 4,
   parameter int                          MAX_FAILS      = 3,
   parameter int                          LOCKOUT_CYCLES = 16
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [CODE_W-1:0]                     code_in,
   input  logic                                  enter,
   output logic                                  unlocked,
   output logic                                  lockout,
   output logic [clog2_safe(N_STEPS)-1:0]        step,
   output logic [clog2_safe(MAX_FAILS+1)-1:0]    fails,
   output logic                                  err
);

   localparam int SW = clog2_safe(N_STEPS);
   localparam int FW = clog2_safe(MAX_FAILS + 1);
   localparam int TW = clog2_safe(max_int(UNLOCK_CYCLES, LOCKOUT_CYCLES) + 1);

   lock_state_e       state;
   logic [CODE_W-1:0] exp_code;
   logic              in_entry;
   logic              hit;
   logic              miss;
   logic              last;
   logic              resync;
   logic              trip;
   logic              t_load;
   logic [TW-1:0]     t_val;
   logic              t_expired;

   // Entry decode. Everything is gated by enter so code_in is a don't-care
   // when no entry is being made.
   always_comb begin
      exp_code = CODES[int'(step)*CODE_W +: CODE_W];
      in_entry = (state == ENTRY);
      hit      = in_entry && enter && (code_in == exp_code);
      miss     = in_entry && enter && (code_in != exp_code);
      last     = (step == SW'(N_STEPS - 1));
      // A wrong code that happens to be the first code starts a new attempt.
      resync   = (code_in == CODES[CODE_W-1:0]);
      trip     = (MAX_FAILS != 0) && ((int'(fails) + 1) == MAX_FAILS);
      t_load   = (hit && last) || (miss && trip);
      t_val    = (hit && last) ? TW'(UNLOCK_CYCLES - 1) : TW'(LOCKOUT_CYCLES - 1);
   end

   // One timer serves both OPEN and LOCKOUT since they never overlap.
   lock_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (t_load),
      .load_val (t_val),
      .expired  (t_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ENTRY;
         step     <= '0;
         fails    <= '0;
         unlocked <= 1'b0;
         lockout  <= 1'b0;
         err      <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            ENTRY: begin
               if (hit) begin
                  if (last) begin
                     state    <= OPEN;
                     unlocked <= 1'b1;
                     step     <= '0;
                     fails    <= '0;
                  end else begin
                     step <= step + 1'b1;
                  end
               end else if (miss) begin
                  err <= 1'b1;
                  if (trip) begin
                     state   <= LOCKOUT;
                     lockout <= 1'b1;
                     step    <= '0;
                     fails   <= FW'(MAX_FAILS);
                  end else begin
                     // With MAX_FAILS=0 the counter wraps; otherwise hold at the cap.
                     if (MAX_FAILS == 0 || int'(fails) < MAX_FAILS)
                        fails <= fails + 1'b1;
                     step <= resync ? SW'(1) : '0;
                  end
               end
            end
            OPEN: begin
               if (t_expired) begin
                  state    <= ENTRY;
                  unlocked <= 1'b0;
               end
            end
            LOCKOUT: begin
               step <= '0;
               if (t_expired) begin
                  state   <= ENTRY;
                  lockout <= 1'b0;
                  fails   <= '0;
               end
            end
            default: begin
               state    <= ENTRY;
               step     <= '0;
               unlocked <= 1'b0;
               lockout  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_code_lock.sv
// Bench for seq_code_lock: a default instance (3 steps, hold 4, lockout after
// 3 fails for 16 cycles) and a legacy instance (1 step, 1-cycle pulse, no
// lockout) share the same stimulus and are each compared every cycle against
// a cycle-count reference model.
module tb_seq_code_lock;

   localparam logic [14:0] CA = 15'h7590;
   localparam logic [4:0]  CB = 5'b10000;

   typedef struct {
      int prog;
      int fails;
      int open_left;
      int lock_left;
      int err;
   } mdl_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enter = 1'b0;
   logic [4:0] code_in = '0;

   logic       a_unl, a_lck, a_err;
   logic [1:0] a_step, a_fails;
   logic       b_unl, b_lck, b_err;
   logic [0:0] b_step, b_fails;

   mdl_t ma, mb;
   int   n_chk = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   seq_code_lock dut_a (
      .clk(clk), .reset(reset), .code_in(code_in), .enter(enter),
      .unlocked(a_unl), .lockout(a_lck), .step(a_step), .fails(a_fails), .err(a_err)
   );

   seq_code_lock #(
      .CODE_W(5), .N_STEPS(1), .CODES(CB), .UNLOCK_CYCLES(1),
      .MAX_FAILS(0), .LOCKOUT_CYCLES(16)
   ) dut_b (
      .clk(clk), .reset(reset), .code_in(code_in), .enter(enter),
      .unlocked(b_unl), .lockout(b_lck), .step(b_step), .fails(b_fails), .err(b_err)
   );

   function automatic int code_of(input logic [63:0] codes, input int cw, input int k);
      logic [63:0] v;
      v = (codes >> (k * cw)) & ((64'd1 << cw) - 64'd1);
      return int'(v);
   endfunction

   // Reference: progress counter plus remaining-cycle counts for the open
   // and lockout periods.
   function automatic mdl_t mdl_next(input mdl_t m, input bit rst, input bit en, input int c,
                                     input logic [63:0] codes, input int cw, input int n,
                                     input int u, input int maxf, input int l);
      mdl_t r;
      r = m;
      r.err = 0;
      if (rst) begin
         r.prog = 0; r.fails = 0; r.open_left = 0; r.lock_left = 0;
         return r;
      end
      if (m.open_left > 0) begin
         r.open_left = m.open_left - 1;
      end else if (m.lock_left > 0) begin
         r.lock_left = m.lock_left - 1;
         if (r.lock_left == 0) r.fails = 0;
      end else if (en) begin
         if (c == code_of(codes, cw, m.prog)) begin
            if (m.prog == n - 1) begin
               r.prog = 0; r.fails = 0; r.open_left = u;
            end else begin
               r.prog = m.prog + 1;
            end
         end else begin
            r.err   = 1;
            r.fails = m.fails + 1;
            r.prog  = (c == code_of(codes, cw, 0)) ? 1 : 0;
            if (maxf != 0 && r.fails == maxf) begin
               r.lock_left = l;
               r.prog      = 0;
            end
         end
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("a_unlocked", 32'(a_unl),   32'(ma.open_left > 0));
      chk("a_lockout",  32'(a_lck),   32'(ma.lock_left > 0));
      chk("a_step",     32'(a_step),  ma.prog);
      chk("a_fails",    32'(a_fails), ma.fails);
      chk("a_err",      32'(a_err),   ma.err);
      chk("b_unlocked", 32'(b_unl),   32'(mb.open_left > 0));
      chk("b_lockout",  32'(b_lck),   32'(mb.lock_left > 0));
      chk("b_step",     32'(b_step),  mb.prog);
      chk("b_fails",    32'(b_fails), mb.fails % 2);
      chk("b_err",      32'(b_err),   mb.err);
   endtask

   // Drive one cycle of inputs, advance both models at the edge, then compare.
   task automatic cyc(input bit rst, input bit en, input logic [4:0] c);
      reset   = rst;
      enter   = en;
      code_in = c;
      @(posedge clk);
      ma = mdl_next(ma, rst, en, int'(c), 64'(CA), 5, 3, 4, 3, 16);
      mb = mdl_next(mb, rst, en, int'(c), 64'(CB), 5, 1, 1, 0, 16);
      #1;
      reset = 1'b0;
      enter = 1'b0;
      check_all();
   endtask

   task automatic good_seq();
      cyc(0, 1, 5'b10000);
      cyc(0, 1, 5'b01100);
      cyc(0, 1, 5'b11101);
   endtask

   initial begin
      int cnt;
      ma = '{0, 0, 0, 0, 0};
      mb = '{0, 0, 0, 0, 0};

      // reset state
      cyc(1, 0, '0);
      cyc(1, 0, '0);
      chk("rst_step", 32'(a_step), 0);
      chk("rst_unl",  32'(a_unl),  0);

      // 1: correct sequence, 4-cycle unlock
      good_seq();
      chk("t1_open", 32'(a_unl), 1);
      cnt = 1;
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0, '0);
         if (a_unl) cnt++;
         else break;
      end
      chk("t1_len", cnt, 4);

      // 2: wrong second code, then recovery
      cyc(1, 0, '0);
      cyc(0, 1, 5'b10000);
      cyc(0, 1, 5'b00011);
      chk("t2_err",   32'(a_err),   1);
      chk("t2_step",  32'(a_step),  0);
      chk("t2_fails", 32'(a_fails), 1);
      good_seq();
      chk("t2_open",  32'(a_unl),   1);
      chk("t2_fclr",  32'(a_fails), 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, '0);

      // 3: re-sync on first code at step 2
      cyc(1, 0, '0);
      cyc(0, 1, 5'b10000);
      cyc(0, 1, 5'b01100);
      chk("t3_step2", 32'(a_step), 2);
      cyc(0, 1, 5'b10000);
      chk("t3_err",   32'(a_err),   1);
      chk("t3_step",  32'(a_step),  1);
      chk("t3_fails", 32'(a_fails), 1);
      cyc(0, 1, 5'b01100);
      cyc(0, 1, 5'b11101);
      chk("t3_open",  32'(a_unl), 1);

      // 4: lockout for 16 cycles, entries ignored meanwhile
      cyc(1, 0, '0);
      for (int i = 0; i < 3; i++) cyc(0, 1, 5'b00011);
      chk("t4_lock",  32'(a_lck),   1);
      chk("t4_fmax",  32'(a_fails), 3);
      cnt = 1;
      for (int i = 0; i < 40; i++) begin
         cyc(0, 1, 5'(code_of(64'(CA), 5, i % 3)));
         if (a_lck) cnt++;
         else break;
      end
      chk("t4_len",   cnt, 16);
      chk("t4_fclr",  32'(a_fails), 0);
      chk("t4_step",  32'(a_step),  0);
      good_seq();
      chk("t4_open",  32'(a_unl), 1);

      // 5: reset mid-sequence and while open
      cyc(1, 0, '0);
      cyc(0, 1, 5'b10000);
      cyc(0, 1, 5'b01100);
      cyc(1, 1, 5'b11101);
      chk("t5_step", 32'(a_step), 0);
      chk("t5_unl",  32'(a_unl),  0);
      good_seq();
      chk("t5_open", 32'(a_unl), 1);
      cyc(1, 0, '0);
      chk("t5_rst_open", 32'(a_unl), 0);

      // 6: legacy instance, 1-cycle pulse and wrapping fails
      cyc(1, 0, '0);
      cyc(0, 1, 5'b10000);
      chk("t6_pulse", 32'(b_unl), 1);
      cyc(0, 0, '0);
      chk("t6_drop",  32'(b_unl), 0);
      for (int i = 0; i < 10; i++) cyc(0, 1, 5'b00011);
      chk("t6_wrap",  32'(b_fails), 0);
      chk("t6_nolck", 32'(b_lck),   0);

      // randomized traffic, biased toward the next expected code
      cyc(1, 0, '0);
      for (int i = 0; i < 800; i++) begin
         bit         r_rst, r_en;
         int         r;
         logic [4:0] c;
         r_rst = ($urandom_range(0, 199) == 0);
         r_en  = ($urandom_range(0, 3) != 0);
         r     = int'($urandom_range(0, 9));
         if (r < 6)      c = 5'(code_of(64'(CA), 5, ma.prog));
         else if (r < 8) c = 5'b10000;
         else            c = 5'($urandom_range(0, 31));
         cyc(r_rst, r_en, c);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
